// File: rtl/axi_pkg.sv
// Shared constants for the two-master AXI read arbiter: default widths,
// FSM state encoding, and the AXI burst/response encodings used by the block.
// Optional round-robin arbitration is selected in the top with AXI_RR_ARB_EN.
package axi_pkg;

  localparam int AXI_ID_BITS_DEF   = 4;
  localparam int AXI_IDS_BITS_DEF  = 8;
  localparam int AXI_ADDR_BITS_DEF = 32;
  localparam int AXI_LEN_BITS_DEF  = 4;
  localparam int AXI_SIZE_BITS_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_rd_arb_pick.sv
// Picks one of two read-address requesters and returns a one-hot grant.
// Latency: purely combinational. Backpressure: none, the caller samples the
// result only when it is ready to start a new burst.
module axi_rd_arb_pick (
  input  logic [1:0] req_i,      // {M1, M0} request vector
  input  logic       prio_m1_i,  // 1: M1 wins a tie, 0: M0 wins a tie
  output logic [1:0] gnt_o       // {M1, M0} one-hot grant, 0 when no request
);

  // Single requester wins outright; a tie is broken by the priority input.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = prio_m1_i ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-master to one-slave AXI read arbiter, one outstanding burst at a time.
// Latency: AR request -> ARVALID_S one cycle later; R channel is combinational.
// Backpressure: AR held stable until ARREADY_S; RREADY_S follows the granted master.
// Build option: define AXI_RR_ARB_EN for round-robin, otherwise fixed M1 > M0.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int AXI_ID_BITS   = AXI_ID_BITS_DEF,
  parameter int AXI_IDS_BITS  = AXI_IDS_BITS_DEF,
  parameter int AXI_ADDR_BITS = AXI_ADDR_BITS_DEF,
  parameter int AXI_LEN_BITS  = AXI_LEN_BITS_DEF,
  parameter int AXI_SIZE_BITS = AXI_SIZE_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  // master 0 (instruction)
  input  logic [AXI_ID_BITS-1:0]   ARID_M0,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
  input  logic [1:0]               ARBURST_M0,
  input  logic                     ARVALID_M0,
  output logic                     ARREADY_M0,
  output logic [AXI_ID_BITS-1:0]   RID_M0,
  output logic [31:0]              RDATA_M0,
  output logic [1:0]               RRESP_M0,
  output logic                     RLAST_M0,
  output logic                     RVALID_M0,
  input  logic                     RREADY_M0,
  // master 1 (data)
  input  logic [AXI_ID_BITS-1:0]   ARID_M1,
  input  logic [AXI_ADDR_BITS-1:0] ARADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]  ARLEN_M1,
  input  logic [AXI_SIZE_BITS-1:0] ARSIZE_M1,
  input  logic [1:0]               ARBURST_M1,
  input  logic                     ARVALID_M1,
  output logic                     ARREADY_M1,
  output logic [AXI_ID_BITS-1:0]   RID_M1,
  output logic [31:0]              RDATA_M1,
  output logic [1:0]               RRESP_M1,
  output logic                     RLAST_M1,
  output logic                     RVALID_M1,
  input  logic                     RREADY_M1,
  // slave
  output logic [AXI_IDS_BITS-1:0]  ARID_S,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_S,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_S,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE_S,
  output logic [1:0]               ARBURST_S,
  output logic                     ARVALID_S,
  input  logic                     ARREADY_S,
  input  logic [AXI_IDS_BITS-1:0]  RID_S,
  input  logic [31:0]              RDATA_S,
  input  logic [1:0]               RRESP_S,
  input  logic                     RLAST_S,
  input  logic                     RVALID_S,
  output logic                     RREADY_S,
  output logic [1:0]               grant
);

  localparam int IDX_BITS = AXI_IDS_BITS - AXI_ID_BITS;
  localparam int CNT_BITS = AXI_LEN_BITS + 1;

  typedef struct packed {
    logic [AXI_ID_BITS-1:0]   id;
    logic [AXI_ADDR_BITS-1:0] addr;
    logic [AXI_LEN_BITS-1:0]  len;
    logic [AXI_SIZE_BITS-1:0] size;
    logic [1:0]               burst;
  } ar_t;

  arb_state_e          state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  ar_t                 hold_q, hold_d;
  logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
  logic [1:0]          pick_gnt;
  logic                prio_m1;
  logic                sel_m0, sel_m1;
  logic                r_hs;

`ifdef AXI_RR_ARB_EN
  logic prio_m1_q, prio_m1_d;
  assign prio_m1 = prio_m1_q;
`else
  assign prio_m1 = 1'b1;
`endif

  axi_rd_arb_pick u_pick (
    .req_i     ({ARVALID_M1, ARVALID_M0}),
    .prio_m1_i (prio_m1),
    .gnt_o     (pick_gnt)
  );

  // R path is live only while a burst is in DATA and reset is not asserted.
  assign sel_m0 = !rst && (state_q == DATA) && grant_q[0];
  assign sel_m1 = !rst && (state_q == DATA) && grant_q[1];
  assign r_hs   = RVALID_S && RREADY_S;

  // State, grant, holding register, beat counter and tie-break pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      hold_q     <= '0;
      beat_cnt_q <= '0;
`ifdef AXI_RR_ARB_EN
      prio_m1_q  <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      hold_q     <= hold_d;
      beat_cnt_q <= beat_cnt_d;
`ifdef AXI_RR_ARB_EN
      prio_m1_q  <= prio_m1_d;
`endif
    end
  end

  // Next-state: capture the winner in IDLE, hand off on AR, finish on RLAST.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    hold_d     = hold_q;
    beat_cnt_d = beat_cnt_q;
`ifdef AXI_RR_ARB_EN
    prio_m1_d  = prio_m1_q;
`endif
    case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          grant_d = pick_gnt;
          state_d = ADDR;
          if (pick_gnt[1]) begin
            hold_d = '{id: ARID_M1, addr: ARADDR_M1, len: ARLEN_M1,
                       size: ARSIZE_M1, burst: ARBURST_M1};
          end else begin
            hold_d = '{id: ARID_M0, addr: ARADDR_M0, len: ARLEN_M0,
                       size: ARSIZE_M0, burst: ARBURST_M0};
          end
        end
      end
      ADDR: begin
        if (ARREADY_S) begin
          state_d = DATA;
`ifdef AXI_RR_ARB_EN
          // The master just served loses the next tie.
          prio_m1_d = grant_q[0];
`endif
        end
      end
      DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + CNT_BITS'(1);
          // RLAST alone ends the burst; the count never overrides the slave.
          if (RLAST_S) begin
            state_d    = IDLE;
            grant_d    = 2'b00;
            beat_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Outputs: AR from the holding register, R steered by the grant register only.
  always_comb begin
    grant      = rst ? 2'b00 : grant_q;
    ARVALID_S  = !rst && (state_q == ADDR);
    ARID_S     = {IDX_BITS'(grant_q[1]), hold_q.id};
    ARADDR_S   = hold_q.addr;
    ARLEN_S    = hold_q.len;
    ARSIZE_S   = hold_q.size;
    ARBURST_S  = hold_q.burst;
    ARREADY_M0 = ARVALID_S && ARREADY_S && grant_q[0];
    ARREADY_M1 = ARVALID_S && ARREADY_S && grant_q[1];
    RREADY_S   = (sel_m0 && RREADY_M0) || (sel_m1 && RREADY_M1);
    RVALID_M0  = sel_m0 && RVALID_S;
    RVALID_M1  = sel_m1 && RVALID_S;
    RID_M0     = sel_m0 ? RID_S[AXI_ID_BITS-1:0] : '0;
    RID_M1     = sel_m1 ? RID_S[AXI_ID_BITS-1:0] : '0;
    RDATA_M0   = sel_m0 ? RDATA_S : 32'h0;
    RDATA_M1   = sel_m1 ? RDATA_S : 32'h0;
    RRESP_M0   = sel_m0 ? RRESP_S : 2'b00;
    RRESP_M1   = sel_m1 ? RRESP_S : 2'b00;
    RLAST_M0   = sel_m0 && RLAST_S;
    RLAST_M1   = sel_m1 && RLAST_S;
  end

  // Slave-returned index bits are advisory only; the grant register routes.
  logic rid_idx_mismatch;
  assign rid_idx_mismatch = (state_q == DATA) && RVALID_S &&
                            (RID_S[AXI_IDS_BITS-1:AXI_ID_BITS] != IDX_BITS'(grant_q[1]));

  // Grant is one-hot whenever a burst is in flight.
  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    (state_q != IDLE) |-> $onehot(grant_q));

  // Beat count is cleared whenever no burst is in its data phase.
  a_cnt_clear: assert property (@(posedge clk) disable iff (rst)
    (state_q != DATA) |-> (beat_cnt_q == '0));

  c_rid_mismatch: cover property (@(posedge clk) disable iff (rst) rid_idx_mismatch);
  c_incr_burst:   cover property (@(posedge clk) disable iff (rst)
    ARVALID_S && ARREADY_S && (hold_q.burst == BURST_INCR));
  c_err_resp:     cover property (@(posedge clk) disable iff (rst)
    r_hs && (RRESP_S != RESP_OKAY));

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameters SHALL be: AXI_ID_BITS, 4, master ID width; AXI_IDS_BITS, 8, slave-side ID width; AXI_ADDR_BITS, 32, address width; AXI_LEN_BITS, 4, burst length width; AXI_SIZE_BITS, 3, beat size width.
REQ-002 clk  in  1  sole clock; all logic on posedge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 ARID_M{0,1} in AXI_ID_BITS, ARADDR_M{0,1} in 32, ARLEN_M{0,1} in 4, ARSIZE_M{0,1} in 3, ARBURST_M{0,1} in 2, ARVALID_M{0,1} in 1: master read-address requests.
REQ-005 ARREADY_M{0,1}  out  1  address accepted for that master.
REQ-006 RID_M{0,1} out 4, RDATA_M{0,1} out 32, RRESP_M{0,1} out 2, RLAST_M{0,1} out 1, RVALID_M{0,1} out 1: read data returned to each master.
REQ-007 RREADY_M{0,1}  in  1  master accepts a read beat.
REQ-008 ARID_S out 8, ARADDR_S out 32, ARLEN_S out 4, ARSIZE_S out 3, ARBURST_S out 2, ARVALID_S out 1; ARREADY_S in 1: slave read-address channel.
REQ-009 RID_S in 8, RDATA_S in 32, RRESP_S in 2, RLAST_S in 1, RVALID_S in 1; RREADY_S out 1: slave read-data channel.
REQ-010 grant  out  2  one-hot owner of the read channel ({M1,M0}); 2'b00 when idle.

Function
REQ-011 FSM SHALL have states IDLE, ADDR, DATA; one outstanding burst at a time.
REQ-012 IDLE: if any ARVALID_Mx, latch winner's AR fields into holding register, set grant, go to ADDR next cycle; else stay.
REQ-013 Arbitration SHALL default to fixed priority M1 (data) over M0 (instruction) when both are valid in the same cycle.
REQ-014 ADDR: ARVALID_S=1 with registered fields; ARID_S={4'(granted index), held ARID}; ARREADY_Mx pulses 1 cycle for the granted master on the ARVALID_S&&ARREADY_S cycle; next state DATA.
REQ-015 ARVALID_S SHALL stay asserted with stable fields until ARREADY_S; no ARREADY to the losing master.
REQ-016 DATA: RDATA_S/RRESP_S/RLAST_S pass combinationally to the granted master; RID_Mx=RID_S[3:0]; RVALID_Mx=RVALID_S only for the granted master, 0 for the other; RREADY_S=RREADY of granted master.
REQ-017 DATA SHALL exit to IDLE on RVALID_S&&RREADY_S&&RLAST_S regardless of RRESP; grant clears in IDLE.
REQ-018 Beat counter SHALL count accepted beats; RLAST_S arriving before ARLEN+1 beats or absent at beat ARLEN+1 SHALL be forwarded unchanged (count is observational, exposed only for assertions).
REQ-019 RID_S[7:4] mismatching the granted index in DATA SHALL be ignored for routing (grant register is authoritative).
REQ-020 Minimum AR-to-next-AR spacing: one IDLE cycle after RLAST handshake.

Reset
REQ-021 While rst=1: state=IDLE, grant=0, holding register=0, ARVALID_S=0, RREADY_S=0, all ARREADY_Mx=0, all RVALID_Mx=0, beat counter=0, round-robin pointer=M1-first.
REQ-022 rst asserted mid-burst SHALL abandon the burst; no beats forwarded during or after reset.

Configuration
REQ-023 Macro AXI_RR_ARB_EN: when defined, arbitration is round-robin (last-granted master loses a tie; pointer updates on AR handshake); when undefined, fixed priority M1>M0 per REQ-013.

Structure
REQ-024 Package axi_pkg SHALL hold width constants, state enum (IDLE/ADDR/DATA), burst/resp encodings (INCR=2'b01, OKAY=2'b00).
REQ-025 Arbitration decision SHALL be sub-module axi_rd_arb_pick (requests, pointer -> one-hot grant); remainder in axi_read_arbiter.

Verification
REQ-026 Single M0 request ARADDR_M0=0x0000_0010, ARLEN=0 -> ARVALID_S next cycle, ARID_S=8'h00, one beat RDATA 0xDEAD_BEEF on RDATA_M0 with RLAST, grant back to 0.
REQ-027 M0 and M1 valid same cycle, fixed mode -> M1 served first (ARID_S[7:4]=1), M0 served after M1 RLAST plus one IDLE cycle.
REQ-028 AXI_RR_ARB_EN, both masters continuously valid for 4 bursts -> grant order M1,M0,M1,M0.
REQ-029 ARREADY_S held low 5 cycles -> ARVALID_S and ARADDR_S stable all 5 cycles; ARREADY_M pulse exactly once.
REQ-030 ARLEN=3, RREADY_M1 toggling 1/0 -> 4 beats delivered in order, RVALID_M0 never 1, exit on 4th beat.
REQ-031 rst=1 during second beat of 4-beat burst -> all outputs zero next cycle, new M0 request after reset completes normally.
